alink_slave_mc: RTL and testbench

- Parametrised successor of the A-link Wishbone register slave.
- Bridges the CPU Wishbone bus to the A-link TX/RX FIFOs and the per-chip scan/mask/busy controls for a configurable channel count.
- Adds over the previous generation:
  - async active-low reset with defined reset values on every output
  - MASK readback
  - TX overflow / RX underflow protection with sticky flags
  - ERR on unmapped addresses
  - configurable flush length
  - optional RX-threshold interrupt

---
 rtl/alink_slave_mc.sv | 181 ++++++++++++++++++
 tb/tb_alink_slave_mc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alink_slave_mc.sv
// A-link Wishbone register slave: bridges the CPU bus to the A-link TX/RX FIFOs and per-chip scan/mask/busy controls.
// Optional RX-threshold/error interrupt and the IRQ_CTRL register at 0x14 are built when ALINK_IRQ_EN is defined.
module alink_slave_mc #(
  parameter int unsigned NUM_CH    = 32,
  parameter int unsigned RXCNT_W   = 10,
  parameter int unsigned TXCNT_W   = 11,
  parameter int unsigned FLUSH_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ALINK_CYC_I,
  input  logic               ALINK_STB_I,
  input  logic               ALINK_WE_I,
  input  logic [5:0]         ALINK_ADR_I,
  input  logic [31:0]        ALINK_DAT_I,
  input  logic [3:0]         ALINK_SEL_I,
  output logic               ALINK_ACK_O,
  output logic               ALINK_ERR_O,
  output logic               ALINK_RTY_O,
  output logic [31:0]        ALINK_DAT_O,
  output logic               txfifo_push,
  output logic [31:0]        txfifo_din,
  input  logic               txfull,
  input  logic [TXCNT_W-1:0] txcnt,
  output logic               rxfifo_pop,
  input  logic [31:0]        rxfifo_dout,
  input  logic               rxempty,
  input  logic [RXCNT_W-1:0] rxcnt,
  output logic               reg_flush,
  output logic               reg_scan,
  output logic [NUM_CH-1:0]  reg_mask,
  input  logic [NUM_CH-1:0]  busy,
  output logic               irq
);

  localparam int unsigned FLW     = 8;
  localparam logic [31:0] DEAD    = 32'hDEADDEAD;
  localparam logic [5:0]  A_TX    = 6'h00;
  localparam logic [5:0]  A_STATE = 6'h04;
  localparam logic [5:0]  A_MASK  = 6'h08;
  localparam logic [5:0]  A_BUSY  = 6'h0C;
  localparam logic [5:0]  A_RX    = 6'h10;
`ifdef ALINK_IRQ_EN
  localparam logic [5:0]  A_IRQ   = 6'h14;
`endif

  logic           w_acc;
  logic           w_mapped;
  logic           w_wr;
  logic           w_rd;
  logic           w_tx_wr;
  logic           w_st_wr;
  logic           w_rx_rd;
  logic           w_tx_ok;
  logic [31:0]    w_state;
  logic [31:0]    w_rdata;
  logic [FLW-1:0] r_flush_cnt;
  logic           r_tx_ovf;
  logic           r_rx_udf;
  logic           w_unused;

`ifdef ALINK_IRQ_EN
  logic               r_rx_en;
  logic               r_err_en;
  logic [RXCNT_W-1:0] r_rx_thr;
  logic               w_irq_wr;
`endif

  assign w_unused    = ^{ALINK_CYC_I, ALINK_SEL_I};
  assign ALINK_RTY_O = 1'b0;

  // A new access is only taken while no response is being presented
  assign w_acc   = ALINK_STB_I & ~ALINK_ACK_O & ~ALINK_ERR_O;
  assign w_wr    = w_acc & w_mapped & ALINK_WE_I;
  assign w_rd    = w_acc & w_mapped & ~ALINK_WE_I;
  assign w_tx_wr = w_wr & (ALINK_ADR_I == A_TX);
  assign w_st_wr = w_wr & (ALINK_ADR_I == A_STATE);
  assign w_rx_rd = w_rd & (ALINK_ADR_I == A_RX);
  assign w_tx_ok = w_tx_wr & ~txfull & ~reg_flush;

  // Show-ahead RX FIFO: pop in the same cycle the head word is captured
  assign rxfifo_pop = w_rx_rd & ~rxempty;
  assign reg_flush  = (r_flush_cnt != '0);

  assign w_state = {reg_scan, rxempty, 14'(rxcnt), 12'(txcnt),
                    r_rx_udf, r_tx_ovf, reg_flush, txfull};

  // Address decode and read-data mux
  always_comb begin
    w_mapped = 1'b0;
    w_rdata  = DEAD;
    case (ALINK_ADR_I)
      A_TX:    w_mapped = 1'b1;
      A_STATE: begin w_mapped = 1'b1; w_rdata = w_state;     end
      A_MASK:  begin w_mapped = 1'b1; w_rdata = 32'(reg_mask); end
      A_BUSY:  begin w_mapped = 1'b1; w_rdata = 32'(busy);     end
      A_RX:    begin w_mapped = 1'b1; w_rdata = rxempty ? DEAD : rxfifo_dout; end
`ifdef ALINK_IRQ_EN
      A_IRQ:   begin
        w_mapped = 1'b1;
        w_rdata  = {2'b00, 14'(r_rx_thr), 14'd0, r_err_en, r_rx_en};
      end
`endif
      default: ;
    endcase
  end

  // Single-cycle ACK/ERR response with registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALINK_ACK_O <= 1'b0;
      ALINK_ERR_O <= 1'b0;
      ALINK_DAT_O <= DEAD;
    end else begin
      ALINK_ACK_O <= w_acc & w_mapped;
      ALINK_ERR_O <= w_acc & ~w_mapped;
      if (w_acc) ALINK_DAT_O <= ALINK_WE_I ? DEAD : w_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txfifo_push <= 1'b0;
      txfifo_din  <= '0;
    end else begin
      txfifo_push <= w_tx_ok;
      if (w_tx_ok) txfifo_din <= ALINK_DAT_I;
    end
  end

  // Sticky error flags: a set event takes priority over write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      if (w_tx_wr & txfull)                r_tx_ovf <= 1'b1;
      else if (w_st_wr & ALINK_DAT_I[2])   r_tx_ovf <= 1'b0;
      if (w_rx_rd & rxempty)               r_rx_udf <= 1'b1;
      else if (w_st_wr & ALINK_DAT_I[3])   r_rx_udf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
      reg_scan    <= 1'b0;
      reg_mask    <= '0;
    end else begin
      if (w_st_wr & ALINK_DAT_I[1]) r_flush_cnt <= FLW'(FLUSH_LEN);
      else if (reg_flush)           r_flush_cnt <= r_flush_cnt - FLW'(1);
      if (w_st_wr) reg_scan <= ALINK_DAT_I[31];
      if (w_wr & (ALINK_ADR_I == A_MASK)) reg_mask <= ALINK_DAT_I[NUM_CH-1:0];
    end
  end

`ifdef ALINK_IRQ_EN
  assign w_irq_wr = w_wr & (ALINK_ADR_I == A_IRQ);

  // Level interrupt: RX level at/above a nonzero threshold, or any sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_en  <= 1'b0;
      r_err_en <= 1'b0;
      r_rx_thr <= '0;
      irq      <= 1'b0;
    end else begin
      if (w_irq_wr) begin
        r_rx_en  <= ALINK_DAT_I[0];
        r_err_en <= ALINK_DAT_I[1];
        r_rx_thr <= ALINK_DAT_I[16 +: RXCNT_W];
      end
      irq <= (r_rx_en & (r_rx_thr != '0) & (rxcnt >= r_rx_thr)) |
             (r_err_en & (r_tx_ovf | r_rx_udf));
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_alink_slave_mc.sv
// Bench for alink_slave_mc: register-map model compared every cycle, directed scenarios plus random traffic.
module tb_alink_slave_mc;
  localparam int unsigned NUM_CH    = 20;
  localparam int unsigned RXCNT_W   = 10;
  localparam int unsigned TXCNT_W   = 11;
  localparam int unsigned FLUSH_LEN = 4;
  localparam logic [31:0] DEAD      = 32'hDEADDEAD;
`ifdef ALINK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic cyc, stb, we;
  logic [5:0] adr;
  logic [31:0] dat_i;
  logic [3:0] sel;
  logic ack, err, rty;
  logic [31:0] dat_o;
  logic txfifo_push;
  logic [31:0] txfifo_din;
  logic txfull;
  logic [TXCNT_W-1:0] txcnt;
  logic rxfifo_pop;
  logic [31:0] rxfifo_dout;
  logic rxempty;
  logic [RXCNT_W-1:0] rxcnt;
  logic reg_flush, reg_scan, irq;
  logic [NUM_CH-1:0] reg_mask, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alink_slave_mc #(.NUM_CH(NUM_CH), .RXCNT_W(RXCNT_W), .TXCNT_W(TXCNT_W), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALINK_CYC_I(cyc), .ALINK_STB_I(stb), .ALINK_WE_I(we), .ALINK_ADR_I(adr),
    .ALINK_DAT_I(dat_i), .ALINK_SEL_I(sel),
    .ALINK_ACK_O(ack), .ALINK_ERR_O(err), .ALINK_RTY_O(rty), .ALINK_DAT_O(dat_o),
    .txfifo_push(txfifo_push), .txfifo_din(txfifo_din), .txfull(txfull), .txcnt(txcnt),
    .rxfifo_pop(rxfifo_pop), .rxfifo_dout(rxfifo_dout), .rxempty(rxempty), .rxcnt(rxcnt),
    .reg_flush(reg_flush), .reg_scan(reg_scan), .reg_mask(reg_mask), .busy(busy), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural register-map model, one transaction decision per clock
  logic        m_ack, m_err, m_push, m_scan, m_ovf, m_udf, m_irq, m_rxen, m_erren;
  logic [31:0] m_dat, m_din, m_mask;
  int          m_flcnt;
  int unsigned m_thr;
  bit          m_acc, m_mapped, m_flushing, m_irq_nxt;
  logic [31:0] m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack = 0; m_err = 0; m_push = 0; m_scan = 0; m_ovf = 0; m_udf = 0; m_irq = 0;
      m_rxen = 0; m_erren = 0; m_thr = 0; m_dat = DEAD; m_din = 0; m_mask = 0; m_flcnt = 0;
    end else begin
      m_acc      = stb && !m_ack && !m_err;
      m_mapped   = (adr == 6'h00) || (adr == 6'h04) || (adr == 6'h08) || (adr == 6'h0C) ||
                   (adr == 6'h10) || (IRQ_ON && adr == 6'h14);
      m_flushing = (m_flcnt != 0);
      m_irq_nxt  = (m_rxen && m_thr != 0 && int'(rxcnt) >= int'(m_thr)) || (m_erren && (m_ovf || m_udf));
      m_push     = 0;
      if (m_flcnt > 0) m_flcnt = m_flcnt - 1;
      m_ack = m_acc && m_mapped;
      m_err = m_acc && !m_mapped;
      if (m_acc) begin
        m_rd = DEAD;
        if (m_mapped && we) begin
          case (adr)
            6'h00: if (txfull) m_ovf = 1;
                   else if (!m_flushing) begin m_push = 1; m_din = dat_i; end
            6'h04: begin
              m_scan = dat_i[31];
              if (dat_i[1]) m_flcnt = FLUSH_LEN;
              if (dat_i[2]) m_ovf = 0;
              if (dat_i[3]) m_udf = 0;
            end
            6'h08: m_mask = dat_i & ((32'd1 << NUM_CH) - 32'd1);
            6'h14: begin
              m_rxen = dat_i[0]; m_erren = dat_i[1];
              m_thr = (dat_i >> 16) % (1 << RXCNT_W);
            end
            default: ;
          endcase
        end else if (m_mapped) begin
          case (adr)
            6'h04: m_rd = (32'(m_scan) << 31) + (32'(rxempty) << 30) + (32'(rxcnt) << 16) +
                          (32'(txcnt) << 4) + (32'(m_udf) << 3) + (32'(m_ovf) << 2) +
                          (32'(m_flushing) << 1) + 32'(txfull);
            6'h08: m_rd = m_mask;
            6'h0C: m_rd = 32'(busy);
            6'h10: if (rxempty) m_udf = 1; else m_rd = rxfifo_dout;
            6'h14: m_rd = (m_thr << 16) + (32'(m_erren) << 1) + 32'(m_rxen);
            default: ;
          endcase
        end
        m_dat = m_rd;
      end
      m_irq = IRQ_ON ? m_irq_nxt : 1'b0;
    end
  end

  // Compare process: every output against the model each cycle
  bit exp_pop;
  always @(negedge clk) begin
    exp_pop = rst_n && stb && !m_ack && !m_err && !we && adr == 6'h10 && !rxempty;
    chk("ack", 32'(ack), 32'(m_ack));
    chk("err", 32'(err), 32'(m_err));
    chk("rty", 32'(rty), 32'd0);
    chk("dat_o", dat_o, m_dat);
    chk("push", 32'(txfifo_push), 32'(m_push));
    chk("din", txfifo_din, m_din);
    chk("pop", 32'(rxfifo_pop), 32'(exp_pop));
    chk("flush", 32'(reg_flush), 32'(m_flcnt != 0));
    chk("scan", 32'(reg_scan), 32'(m_scan));
    chk("mask", 32'(reg_mask), m_mask);
    chk("irq", 32'(irq), 32'(m_irq));
  end

  // Event counters used by the directed scenarios
  int push_cnt = 0, pop_cnt = 0, fl_run = 0, fl_last = 0;
  always @(negedge clk) begin
    if (txfifo_push) push_cnt++;
    if (rxfifo_pop) pop_cnt++;
    if (reg_flush) fl_run++;
    else begin
      if (fl_run > 0) fl_last = fl_run;
      fl_run = 0;
    end
  end

  task automatic access(input logic w, input logic [5:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    stb = 1; we = w; adr = a; dat_i = d;
    @(posedge clk); #1;
    lat = 1;
    while (lat < 8 && !(ack || err)) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(ack || err)) chk("resp_timeout", 32'(lat), 32'd0);
    rd = dat_o;
    er = err;
    stb = 0; we = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [31:0] rd;
  logic er;
  int lat, pc;

  initial begin
    rst_n = 1; cyc = 0; stb = 0; we = 0; adr = 0; dat_i = 0; sel = 4'hF;
    txfull = 0; txcnt = 11'd5; rxfifo_dout = 0; rxempty = 1; rxcnt = 0; busy = '0;
    #1 rst_n = 0;
    step(3);
    chk("rst_dat", dat_o, DEAD);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_mask", 32'(reg_mask), 32'd0);
    rst_n = 1;

    access(0, 6'h04, 0, rd, er, lat);
    chk("state_lat", 32'(lat), 32'd1);
    chk("state_rd", rd, 32'h40000050);

    pc = push_cnt;
    access(1, 6'h00, 32'h12345678, rd, er, lat);
    chk("push_din", txfifo_din, 32'h12345678);
    chk("push_one", 32'(txfifo_push), 32'd1);
    txfull = 1;
    access(1, 6'h00, 32'h0BADF00D, rd, er, lat);
    txfull = 0;
    step(1);
    chk("push_count", 32'(push_cnt - pc), 32'd1);
    access(0, 6'h04, 0, rd, er, lat);
    chk("ovf_set", rd, 32'h40000054);
    access(1, 6'h04, 32'h4, rd, er, lat);
    access(0, 6'h04, 0, rd, er, lat);
    chk("ovf_clr", rd, 32'h40000050);

    pc = pop_cnt;
    rxempty = 0; rxcnt = 1; rxfifo_dout = 32'hA5A5A5A5;
    access(0, 6'h10, 0, rd, er, lat);
    chk("rx_data", rd, 32'hA5A5A5A5);
    rxempty = 1; rxcnt = 0; rxfifo_dout = 32'h11112222;
    access(0, 6'h10, 0, rd, er, lat);
    chk("rx_udf_data", rd, DEAD);
    chk("pop_count", 32'(pop_cnt - pc), 32'd1);
    access(0, 6'h04, 0, rd, er, lat);
    chk("udf_set", rd, 32'h40000058);
    access(1, 6'h04, 32'h8, rd, er, lat);

    pc = push_cnt;
    access(1, 6'h04, 32'h2, rd, er, lat);
    access(1, 6'h04, 32'h2, rd, er, lat);
    access(1, 6'h00, 32'hCAFE0001, rd, er, lat);
    step(10);
    chk("flush_run", 32'(fl_last), 32'd6);
    chk("flush_nopush", 32'(push_cnt - pc), 32'd0);

    access(1, 6'h20, 32'hFFFFFFFF, rd, er, lat);
    chk("unmapped_err", 32'(er), 32'd1);
    chk("unmapped_noack", 32'(ack), 32'd0);
    access(0, 6'h08, 0, rd, er, lat);
    chk("mask_untouched", rd, 32'd0);
    access(1, 6'h08, 32'hFFFF0000, rd, er, lat);
    access(0, 6'h08, 0, rd, er, lat);
    chk("mask_rd", rd, 32'h000F0000);
    busy = 20'hABCDE;
    access(0, 6'h0C, 0, rd, er, lat);
    chk("busy_rd", rd, 32'h000ABCDE);

    access(1, 6'h14, 32'h00080001, rd, er, lat);
    chk("irq_ctrl_map", 32'(er), IRQ_ON ? 32'd0 : 32'd1);
`ifdef ALINK_IRQ_EN
    access(0, 6'h14, 0, rd, er, lat);
    chk("irq_ctrl_rd", rd, 32'h00080001);
    rxempty = 0; rxcnt = 7; rxfifo_dout = 32'h5;
    step(2);
    chk("irq_below", 32'(irq), 32'd0);
    rxcnt = 8;
    step(1);
    chk("irq_rise", 32'(irq), 32'd1);
    access(0, 6'h10, 0, rd, er, lat);
    rxcnt = 7;
    step(1);
    chk("irq_fall", 32'(irq), 32'd0);
    access(1, 6'h14, 0, rd, er, lat);
`endif

    // Randomized traffic with one asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      stb = ($urandom_range(0, 2) != 0);
      we = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: adr = 6'h00; 1: adr = 6'h04; 2: adr = 6'h08;
        3: adr = 6'h0C; 4: adr = 6'h10; 5: adr = 6'h14;
        default: adr = 6'($urandom);
      endcase
      dat_i = $urandom;
      txfull = ($urandom_range(0, 3) == 0);
      txcnt = TXCNT_W'($urandom);
      rxempty = ($urandom_range(0, 3) == 0);
      rxcnt = RXCNT_W'($urandom_range(0, 24));
      rxfifo_dout = $urandom;
      busy = NUM_CH'($urandom);
      if (n == 1500) rst_n = 0;
      if (n == 1503) rst_n = 1;
      step(1);
    end
    stb = 0;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
